inst_fetch_cache: RTL and testbench



---
 rtl/inst_fetch_cache_pkg.sv | 27 ++
 rtl/inst_fetch_cache_array.sv | 69 ++++++
 rtl/inst_fetch_cache.sv | 157 +++++++++++++++
 tb/tb_inst_fetch_cache.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_cache_pkg.sv
// -----------------------------------------------------------------------------
// inst_fetch_cache_pkg
// Shared definitions for the instruction-fetch cache:
//   - FSM state encoding (ST_LOOKUP, ST_REFILL)
//   - default address / instruction widths
//   - index/tag width helpers derived from the line count
// -----------------------------------------------------------------------------
package inst_fetch_cache_pkg;

  localparam int AW_DEF = 8;
  localparam int IW_DEF = 9;

  // FSM encoding, kept as plain constants so existing tooling can decode it.
  localparam logic [0:0] ST_LOOKUP = 1'b0;
  localparam logic [0:0] ST_REFILL = 1'b1;

  // Index bits needed to address 'lines' cache lines.
  function automatic int idx_w(input int lines);
    return $clog2(lines);
  endfunction

  // Tag bits left over once the index is taken from the low address bits.
  function automatic int tag_w(input int aw, input int lines);
    return aw - $clog2(lines);
  endfunction

endpackage

// File: rtl/inst_fetch_cache_array.sv
// -----------------------------------------------------------------------------
// icache_array
// Direct-mapped storage for the instruction cache: per-line valid bit, tag and
// data word. Combinational read port, one synchronous write port, flush-all.
//
// Ports:
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset (clears valid bits only)
//   flush    in   clears every valid bit at the next edge; beats a write
//   rd_idx   in   lookup index
//   rd_tag   in   lookup tag
//   rd_hit   out  line at rd_idx is valid and its tag matches rd_tag
//   rd_data  out  data word stored at rd_idx
//   wr_en    in   write enable (line becomes valid)
//   wr_idx   in   write index
//   wr_tag   in   write tag
//   wr_data  in   write data
// -----------------------------------------------------------------------------
module icache_array
  import inst_fetch_cache_pkg::*;
#(
  parameter int LINES = 16,
  parameter int AW    = AW_DEF,
  parameter int IW    = IW_DEF,
  parameter int IDX   = idx_w(LINES),
  parameter int TW    = tag_w(AW, LINES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic [IDX-1:0] rd_idx,
  input  logic [TW-1:0]  rd_tag,
  output logic           rd_hit,
  output logic [IW-1:0]  rd_data,
  input  logic           wr_en,
  input  logic [IDX-1:0] wr_idx,
  input  logic [TW-1:0]  wr_tag,
  input  logic [IW-1:0]  wr_data
);

  logic [LINES-1:0] valid;
  logic [TW-1:0]    tag_mem  [LINES];
  logic [IW-1:0]    data_mem [LINES];

  // Valid bits carry all the state that matters after reset or flush.
  // NOTE: sequential state is updated with non-blocking (<=) so every
  // always_ff reads the pre-edge value regardless of evaluation order.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_idx] <= 1'b1;
    end
  end

  // NOTE: the tag/data arrays are deliberately left out of reset; the valid
  // bit gates their use, and a resettable array would cost a reset tree on
  // every storage bit for no functional gain.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= wr_data;
    end
  end

  assign rd_hit  = valid[rd_idx] && (tag_mem[rd_idx] == rd_tag);
  assign rd_data = data_mem[rd_idx];

endmodule

// File: rtl/inst_fetch_cache.sv
// -----------------------------------------------------------------------------
// inst_fetch_cache
// Instruction-fetch stage in front of the 8-bit datapath. Looks up pc in a
// small direct-mapped cache (zero-latency on a hit). On a miss it raises
// stall, refills the line from instruction memory over req/ack, then replays
// the lookup, which hits the following cycle.
//
// Optional feature: define FETCH_PERF_EN to add the hit_cnt/miss_cnt
// saturating performance counters.
//
// Ports:
//   clk         in   clock, rising edge
//   rst         in   synchronous active-high reset
//   pc          in   fetch address (must hold while stall=1)
//   flush       in   one-cycle pulse, invalidates all lines
//   inst        out  instruction word, 0 when inst_valid=0
//   inst_valid  out  inst is a hit for the current pc
//   stall       out  datapath must hold pc and write enables
//   imem_req    out  registered refill request
//   imem_addr   out  registered refill address, stable while imem_req=1
//   imem_ack    in   memory response, imem_rdata valid this cycle
//   imem_rdata  in   returned instruction word
//   hit_cnt     out  (FETCH_PERF_EN) LOOKUP cycles that hit, saturating
//   miss_cnt    out  (FETCH_PERF_EN) LOOKUP->REFILL transitions, saturating
// -----------------------------------------------------------------------------
module inst_fetch_cache
  import inst_fetch_cache_pkg::*;
#(
  parameter int LINES = 16,
  parameter int AW    = AW_DEF,
  parameter int IW    = IW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] pc,
  input  logic          flush,
  output logic [IW-1:0] inst,
  output logic          inst_valid,
  output logic          stall,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [IW-1:0] imem_rdata
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]   hit_cnt,
  output logic [15:0]   miss_cnt
`endif
);

  localparam int IDX = idx_w(LINES);
  localparam int TW  = tag_w(AW, LINES);

  generate
    if (LINES < 2 || LINES > 64 || (LINES & (LINES - 1)) != 0) begin : g_bad_lines
      $error("inst_fetch_cache: LINES must be a power of 2 in 2..64");
    end
  endgenerate

  logic [0:0]    state;
  logic          arr_hit;
  logic [IW-1:0] arr_data;
  logic          lookup_hit;
  logic          start_refill;
  logic          fill_en;

  icache_array #(
    .LINES (LINES),
    .AW    (AW),
    .IW    (IW),
    .IDX   (IDX),
    .TW    (TW)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .rd_idx  (pc[IDX-1:0]),
    .rd_tag  (pc[AW-1:IDX]),
    .rd_hit  (arr_hit),
    .rd_data (arr_data),
    .wr_en   (fill_en),
    .wr_idx  (imem_addr[IDX-1:0]),
    .wr_tag  (imem_addr[AW-1:IDX]),
    .wr_data (imem_rdata)
  );

  // Datapath-facing outputs. Reset forces them quiet so the datapath neither
  // stalls nor consumes a stale word while the cache is being reset.
  // NOTE: every always_comb output gets a default first, so no path through
  // the block can leave a value unassigned and infer a latch.
  always_comb begin
    lookup_hit   = 1'b0;
    start_refill = 1'b0;
    fill_en      = 1'b0;
    inst         = '0;
    inst_valid   = 1'b0;
    stall        = 1'b0;
    if (!rst) begin
      lookup_hit   = (state == ST_LOOKUP) && arr_hit;
      start_refill = (state == ST_LOOKUP) && !arr_hit;
      // Flush beats a simultaneous ack: the returned word is discarded.
      fill_en      = (state == ST_REFILL) && imem_ack && !flush;
      inst_valid   = lookup_hit;
      inst         = lookup_hit ? arr_data : '0;
      stall        = !lookup_hit;
    end
  end

  // Refill FSM and request/address registers. The fill always uses the
  // latched imem_addr, so a pc that moves during stall only causes a re-miss.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_LOOKUP;
      imem_req  <= 1'b0;
      imem_addr <= '0;
    end else begin
      case (state)
        ST_LOOKUP: begin
          if (start_refill) begin
            state     <= ST_REFILL;
            imem_req  <= 1'b1;
            imem_addr <= pc;
          end
        end
        ST_REFILL: begin
          // Flush abandons the request; ack completes it. Either way return.
          if (flush || imem_ack) begin
            state    <= ST_LOOKUP;
            imem_req <= 1'b0;
          end
        end
        default: begin
          state    <= ST_LOOKUP;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  // Saturating counters; survive flush, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (lookup_hit && hit_cnt != 16'hFFFF) begin
        hit_cnt <= hit_cnt + 16'd1;
      end
      if (start_refill && miss_cnt != 16'hFFFF) begin
        miss_cnt <= miss_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_inst_fetch_cache.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch_cache
// Directed bench for inst_fetch_cache (LINES=16). Inputs change 1 ns after the
// rising edge; outputs are sampled once the new inputs have settled.
// -----------------------------------------------------------------------------
module tb_inst_fetch_cache;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] pc;
  logic       flush;
  logic [8:0] inst;
  logic       inst_valid;
  logic       stall;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic       imem_ack;
  logic [8:0] imem_rdata;
`ifdef FETCH_PERF_EN
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  inst_fetch_cache #(.LINES(16), .AW(8), .IW(9)) dut (
    .clk        (clk),
    .rst        (rst),
    .pc         (pc),
    .flush      (flush),
    .inst       (inst),
    .inst_valid (inst_valid),
    .stall      (stall),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata)
`ifdef FETCH_PERF_EN
    ,
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Take a miss on address a, return d after lat request cycles (lat >= 1),
  // and verify the stall length, request address and the replayed hit.
  task automatic fetch_miss(input logic [7:0] a, input logic [8:0] d, input int lat);
    int stalls;
    stalls = 0;
    pc = a;
    #1;
    check("miss_valid", 32'(inst_valid), 32'd0);
    check("miss_inst", 32'(inst), 32'd0);
    if (stall) stalls++;
    tick();
    check("req_raise", 32'(imem_req), 32'd1);
    check("req_addr", 32'(imem_addr), 32'(a));
    for (int i = 1; i < lat; i++) begin
      if (stall) stalls++;
      tick();
      check("req_hold", 32'(imem_req), 32'd1);
    end
    imem_ack   = 1'b1;
    imem_rdata = d;
    #1;
    if (stall) stalls++;
    tick();
    imem_ack   = 1'b0;
    imem_rdata = 9'h000;
    #1;
    check("miss_penalty", 32'(stalls), 32'(lat + 1));
    check("replay_valid", 32'(inst_valid), 32'd1);
    check("replay_inst", 32'(inst), 32'(d));
    check("replay_stall", 32'(stall), 32'd0);
    check("replay_req", 32'(imem_req), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    pc         = 8'h05;
    flush      = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = 9'h000;

    // Reset: forced combinational outputs and cleared registers.
    tick();
    tick();
    check("rst_inst", 32'(inst), 32'd0);
    check("rst_valid", 32'(inst_valid), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_addr", 32'(imem_addr), 32'd0);
    rst = 1'b0;
    #1;
    check("cold_stall", 32'(stall), 32'd1);

    // Cold miss, ack in the third request cycle: four stall cycles.
    fetch_miss(8'h05, 9'h1A3, 3);

    // Held pc keeps hitting with no request and no stall.
    for (int i = 0; i < 4; i++) begin
      tick();
      check("hit_valid", 32'(inst_valid), 32'd1);
      check("hit_inst", 32'(inst), 32'h1A3);
      check("hit_stall", 32'(stall), 32'd0);
      check("hit_req", 32'(imem_req), 32'd0);
    end

    // Ack while no request is outstanding must be ignored.
    imem_ack   = 1'b1;
    imem_rdata = 9'h1FF;
    tick();
    imem_ack   = 1'b0;
    imem_rdata = 9'h000;
    #1;
    check("stray_ack_inst", 32'(inst), 32'h1A3);
    check("stray_ack_req", 32'(imem_req), 32'd0);

    // Conflict: 0x03 and 0x13 share index 3 and evict each other.
    fetch_miss(8'h03, 9'h011, 1);
    fetch_miss(8'h13, 9'h122, 2);
    fetch_miss(8'h03, 9'h011, 1);

    // Flush together with ack: line not written, request dropped.
    pc = 8'h20;
    tick();
    check("fl_req", 32'(imem_req), 32'd1);
    check("fl_addr", 32'(imem_addr), 32'h20);
    flush      = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 9'h0AA;
    tick();
    flush      = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = 9'h000;
    #1;
    check("fl_req_drop", 32'(imem_req), 32'd0);
    check("fl_remiss_valid", 32'(inst_valid), 32'd0);
    check("fl_remiss_stall", 32'(stall), 32'd1);
    tick();
    check("fl_rereq", 32'(imem_req), 32'd1);
    check("fl_rereq_addr", 32'(imem_addr), 32'h20);
    imem_ack   = 1'b1;
    imem_rdata = 9'h0BB;
    tick();
    imem_ack   = 1'b0;
    imem_rdata = 9'h000;
    #1;
    check("fl_fill_inst", 32'(inst), 32'h0BB);
    check("fl_fill_valid", 32'(inst_valid), 32'd1);

    // The flush also invalidated 0x03, filled before it.
    pc = 8'h03;
    #1;
    check("fl_old_line", 32'(inst_valid), 32'd0);

    // Reset mid-refill: 0x03 is outstanding when rst arrives.
    tick();
    check("mr_req", 32'(imem_req), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("mr_req_clr", 32'(imem_req), 32'd0);
    check("mr_addr_clr", 32'(imem_addr), 32'd0);
    pc = 8'h20;
    #1;
    check("mr_prev_miss", 32'(inst_valid), 32'd0);
    check("mr_prev_stall", 32'(stall), 32'd1);
    tick();
    check("mr_lookup_req", 32'(imem_req), 32'd1);
    check("mr_lookup_addr", 32'(imem_addr), 32'h20);

`ifdef FETCH_PERF_EN
    // One miss then five hit cycles, from a fresh reset.
    rst = 1'b1;
    tick();
    check("perf_rst_hit", 32'(hit_cnt), 32'd0);
    check("perf_rst_miss", 32'(miss_cnt), 32'd0);
    rst = 1'b0;
    fetch_miss(8'h05, 9'h1A3, 1);
    for (int i = 0; i < 5; i++) tick();
    check("perf_hit_cnt", 32'(hit_cnt), 32'd5);
    check("perf_miss_cnt", 32'(miss_cnt), 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    check("perf_flush_keep", 32'(miss_cnt), 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
